uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 66 ++++++
 tb/tb_uart_rx_fifo.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between uart_rx and its consumer.
// First-word fall-through output, sticky overflow flag, synchronous active-low reset.
module uart_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_valid,
  output logic                  o_accept,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_accept,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  input  logic                  i_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign o_accept = !full;
  assign o_valid  = !empty;
  assign o_count  = wr_ptr - rd_ptr;
  assign o_data   = mem[rd_ptr[PW-2:0]];

  assign push = i_valid && o_accept;
  assign pop  = o_valid && i_accept;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; the reset-edge write is suppressed.
  always_ff @(posedge i_clk) begin
    if (i_nrst && push) mem[wr_ptr[PW-2:0]] <= i_data;
  end

  // A new overflow on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_nrst)               o_overflow <= 1'b0;
    else if (i_valid && full)  o_overflow <= 1'b1;
    else if (i_clear)          o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model of the FIFO behaviour.
module tb_uart_rx_fifo;
  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                i_clk = 1'b0;
  logic                i_nrst = 1'b0;
  logic [WIDTH-1:0]    i_data = '0;
  logic                i_valid = 1'b0;
  logic                o_accept;
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                i_accept = 1'b0;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overflow;
  logic                i_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf = 1'b0;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_accept  (o_accept),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_accept  (i_accept),
    .o_count   (o_count),
    .o_overflow(o_overflow),
    .i_clear   (i_clear)
  );

  // 12 MHz clock, 83 ns period
  always begin
    #42 i_clk = 1'b1;
    #41 i_clk = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the reference FIFO.
  task automatic model_edge(input bit nrst, input bit v, input logic [WIDTH-1:0] d,
                            input bit a, input bit c);
    bit was_full;
    bit do_pop;
    bit do_push;
    if (!nrst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      do_pop   = (model_q.size() != 0) && a;
      do_push  = v && !was_full;
      if (v && was_full) model_ovf = 1'b1;
      else if (c)        model_ovf = 1'b0;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(o_count), 32'(model_q.size()));
    chk("valid", 32'(o_valid), 32'(model_q.size() != 0));
    chk("accept", 32'(o_accept), 32'(model_q.size() != DEPTH));
    chk("overflow", 32'(o_overflow), 32'(model_ovf));
    if (model_q.size() != 0) chk("data", 32'(o_data), 32'(model_q[0]));
  endtask

  task automatic step(input bit nrst, input bit v, input logic [WIDTH-1:0] d,
                      input bit a, input bit c);
    i_nrst   = nrst;
    i_valid  = v;
    i_data   = d;
    i_accept = a;
    i_clear  = c;
    @(posedge i_clk);
    model_edge(nrst, v, d, a, c);
    @(negedge i_clk);
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge i_clk);
    do_reset();
    chk("rst_count", 32'(o_count), 0);
    chk("rst_accept", 32'(o_accept), 1);

    // Single byte with consumer stalled is visible the cycle after the push.
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    chk("first_data", 32'(o_data), 32'h11);
    chk("first_valid", 32'(o_valid), 1);

    // Fill to 16, then offer a byte while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_count", 32'(o_count), 16);
    chk("full_accept", 32'(o_accept), 0);
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(o_overflow), 1);
    chk("ovf_head", 32'(o_data), 32'h00);
    // Clear together with a fresh overflow: the set must win.
    step(1'b1, 1'b1, 8'hAB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(o_overflow), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(o_overflow), 0);
    // Pop from full: accept returns only after the edge.
    step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0);
    chk("pop_full_count", 32'(o_count), 15);
    chk("pop_full_accept", 32'(o_accept), 1);
    for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("drained", 32'(o_count), 0);

    // Hold 8 entries with simultaneous push/pop across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("steady_count", 32'(o_count), 8);

    // Reset mid-operation with count 5 and overflow set; push/pop on that edge ignored.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(o_count), 5);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("mid_rst_count", 32'(o_count), 0);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_accept", 32'(o_accept), 1);
    chk("mid_rst_ovf", 32'(o_overflow), 0);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < 60),
           8'($urandom),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
